// File: rtl/mem_pkg.sv
// Shared definitions for the data memory controller: controller states,
// default geometry and the word-alignment helper.
package mem_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 10;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // A byte address is only usable when it points at the first byte of a word.
    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return (addr_lsb != 2'b00);
    endfunction

endpackage

// File: rtl/mem_array_be.sv
// Single-port synchronous RAM with per-byte write enables. The read register
// yields zero on any cycle that is not a read, so downstream needs no masking.
module mem_array_be #(
    parameter int DATA_W = 32,
    parameter int AW     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                we,
    input  logic [DATA_W/8-1:0] be,
    input  logic [AW-1:0]       addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata
);

    localparam int BE_W  = DATA_W / 8;
    localparam int DEPTH = 2 ** AW;

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Byte-masked write port; storage itself is never reset.
    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be[b]) begin
                    mem_r[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // Read register: captures the word as it stood before this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= {DATA_W{1'b0}};
        end else if (en && !we) begin
            rdata <= mem_r[addr];
        end else begin
            rdata <= {DATA_W{1'b0}};
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: clears the array after reset, then serves aligned
// byte-enabled reads/writes with a fixed-latency in-order response pipeline.
module data_mem_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                init_done
);

    localparam int BE_W = DATA_W / 8;
    localparam int WA_W = ADDR_W - 2;
    localparam logic [WA_W-1:0] LAST_IDX = {WA_W{1'b1}};
    localparam logic [WA_W-1:0] ONE_IDX  = {{(WA_W-1){1'b0}}, 1'b1};

    state_t            state_r;
    logic [WA_W-1:0]   cnt_r;
    logic              accept_s;
    logic              misalign_s;
    logic              ram_en_s;
    logic              ram_we_s;
    logic [BE_W-1:0]   ram_be_s;
    logic [WA_W-1:0]   ram_addr_s;
    logic [DATA_W-1:0] ram_wdata_s;
    logic [DATA_W-1:0] ram_rdata_s;
    logic [RD_LAT-1:0] vld_r;
    logic [RD_LAT-1:0] err_r;

    assign accept_s   = req_valid & req_ready;
    assign misalign_s = is_misaligned(req_addr[1:0]);

    // Controller FSM: walk every word during INIT, then stay in RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= INIT;
            cnt_r     <= {WA_W{1'b0}};
            req_ready <= 1'b0;
            init_done <= 1'b0;
        end else begin
            case (state_r)
                INIT: begin
                    cnt_r <= cnt_r + ONE_IDX;
                    if (cnt_r == LAST_IDX) begin
                        state_r   <= RUN;
                        req_ready <= 1'b1;
                        init_done <= 1'b1;
                    end
                end
                RUN: begin
                    state_r <= RUN;
                end
                default: begin
                    state_r   <= INIT;
                    cnt_r     <= {WA_W{1'b0}};
                    req_ready <= 1'b0;
                    init_done <= 1'b0;
                end
            endcase
        end
    end

    // RAM port steering: the clear sweep owns the port in INIT; misaligned
    // requests never reach the array.
    always_comb begin
        ram_en_s    = 1'b0;
        ram_we_s    = 1'b0;
        ram_be_s    = {BE_W{1'b0}};
        ram_addr_s  = cnt_r;
        ram_wdata_s = {DATA_W{1'b0}};
        if (state_r == INIT) begin
            ram_en_s = 1'b1;
            ram_we_s = 1'b1;
            ram_be_s = {BE_W{1'b1}};
        end else if (accept_s && !misalign_s) begin
            ram_en_s    = 1'b1;
            ram_we_s    = req_we;
            ram_be_s    = req_be;
            ram_addr_s  = req_addr[ADDR_W-1:2];
            ram_wdata_s = req_wdata;
        end else begin
            ram_en_s = 1'b0;
        end
    end

    mem_array_be #(
        .DATA_W (DATA_W),
        .AW     (WA_W)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ram_en_s),
        .we    (ram_we_s),
        .be    (ram_be_s),
        .addr  (ram_addr_s),
        .wdata (ram_wdata_s),
        .rdata (ram_rdata_s)
    );

    // Valid/error pipeline; the first stage loads on the acceptance edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_r <= {RD_LAT{1'b0}};
            err_r <= {RD_LAT{1'b0}};
        end else begin
            vld_r[0] <= accept_s;
            err_r[0] <= accept_s & misalign_s;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_r[i] <= vld_r[i-1];
                err_r[i] <= err_r[i-1];
            end
        end
    end

    assign rsp_valid = vld_r[RD_LAT-1];
    assign rsp_err   = err_r[RD_LAT-1];

    // The RAM read register is the first data stage; extra stages follow it.
    if (RD_LAT > 1) begin : g_dly
        logic [DATA_W-1:0] dly_r [RD_LAT-1];

        // Data delay line aligned with the valid pipeline.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < RD_LAT - 1; i++) begin
                    dly_r[i] <= {DATA_W{1'b0}};
                end
            end else begin
                dly_r[0] <= ram_rdata_s;
                for (int i = 1; i < RD_LAT - 1; i++) begin
                    dly_r[i] <= dly_r[i-1];
                end
            end
        end

        assign rsp_rdata = dly_r[RD_LAT-2];
    end else begin : g_nodly
        assign rsp_rdata = ram_rdata_s;
    end

endmodule
